// File: rtl/cmp_pkg.sv
// Shared types and helpers for the chunk-serial compare unit.
package cmp_pkg;

    // Predicate codes as presented on the sel port.
    typedef enum logic [2:0] {
        OP_INVALID0 = 3'd0,
        OP_INVALID1 = 3'd1,
        OP_EQ       = 3'd2,
        OP_NE       = 3'd3,
        OP_LT       = 3'd4,
        OP_GE       = 3'd5,
        OP_LTU      = 3'd6,
        OP_GEU      = 3'd7
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // Signed predicates are handled by flipping the operand sign bits.
    function automatic logic is_signed_op(cmp_op_e op);
        return (op == OP_LT) || (op == OP_GE);
    endfunction

    function automatic logic is_valid_op(logic [2:0] code);
        return (cmp_op_e'(code) != OP_INVALID0) && (cmp_op_e'(code) != OP_INVALID1);
    endfunction

    // Truth value of the predicate given the final ordering of the operands.
    function automatic logic op_truth(cmp_op_e op, logic lt, logic eq);
        logic t;
        t = 1'b0;
        case (op)
            OP_EQ:          t = eq;
            OP_NE:          t = ~eq;
            OP_LT, OP_LTU:  t = lt;
            OP_GE, OP_GEU:  t = ~lt;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational W-bit unsigned magnitude compare.
module cmp_chunk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o,
    output logic         eq_o,
    output logic         gt_o
);

    // Plain unsigned ordering of one chunk.
    always_comb begin
        lt_o = (a_i < b_i);
        eq_o = (a_i == b_i);
        gt_o = (a_i > b_i);
    end

endmodule

// File: rtl/cmp_seq_unit.sv
// Chunk-serial magnitude comparator: scans MSB chunk first, stops on the first
// differing chunk, and reports the selected predicate with a start/done handshake.
module cmp_seq_unit
    import cmp_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    localparam int unsigned NCHUNK = N / CHUNK;
    localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((CHUNK == 0) || (N % CHUNK != 0)) begin : g_bad_chunk
        $error("cmp_seq_unit: N must be a non-zero multiple of CHUNK");
    end

    cmp_state_e       state_q, state_d;
    cmp_op_e          op_q, op_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [N-1:0]     result_q, result_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic [N-1:0]     a_sh, b_sh;
    logic             chunk_lt, chunk_eq, chunk_gt;

    // Bring the current chunk down to bit 0 so one comparator serves every index.
    always_comb begin
        a_sh = a_q >> (idx_q * CHUNK);
        b_sh = b_q >> (idx_q * CHUNK);
    end

    cmp_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .a_i  (a_sh[CHUNK-1:0]),
        .b_i  (b_sh[CHUNK-1:0]),
        .lt_o (chunk_lt),
        .eq_o (chunk_eq),
        .gt_o (chunk_gt)
    );

    // Next-state: accept in IDLE/DONE, scan one chunk per cycle, hold results otherwise.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        result_d = result_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (is_valid_op(sel)) begin
                        op_d  = cmp_op_e'(sel);
                        a_d   = a;
                        b_d   = b;
                        // Flipping both sign bits maps two's-complement order onto unsigned.
                        if (is_signed_op(cmp_op_e'(sel))) begin
                            a_d[N-1] = ~a[N-1];
                            b_d[N-1] = ~b[N-1];
                        end
                        idx_d   = IdxW'(NCHUNK - 1);
                        state_d = SCAN;
                    end else begin
                        result_d = '0;
                        lt_d     = 1'b0;
                        eq_d     = 1'b0;
                        gt_d     = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            SCAN: begin
                if (!chunk_eq) begin
                    lt_d        = chunk_lt;
                    eq_d        = 1'b0;
                    gt_d        = chunk_gt;
                    result_d    = '0;
                    result_d[0] = op_truth(op_q, chunk_lt, 1'b0);
                    state_d     = DONE;
                end else if (idx_q == '0) begin
                    lt_d        = 1'b0;
                    eq_d        = 1'b1;
                    gt_d        = 1'b0;
                    result_d    = '0;
                    result_d[0] = op_truth(op_q, 1'b0, 1'b1);
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; synchronous reset aborts any scan without a done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_INVALID0;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            result_q <= '0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy   = (state_q == SCAN);
        done   = (state_q == DONE);
        result = result_q;
        lt     = lt_q;
        eq     = eq_q;
        gt     = gt_q;
    end

endmodule

// File: tb/tb_cmp_seq_unit.sv
// Randomised and directed bench for cmp_seq_unit against an arithmetic reference model.
module tb_cmp_seq_unit;

    localparam int N      = 8;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = N / CHUNK;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   sel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         lt;
    logic         eq;
    logic         gt;

    int vectors;
    int miscompares;

    cmp_seq_unit #(
        .N     (N),
        .CHUNK (CHUNK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sel    (sel),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .lt     (lt),
        .eq     (eq),
        .gt     (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: ordering from integer compares, latency from the highest differing chunk.
    function automatic void ref_model(input logic [2:0] s, input logic [N-1:0] x,
                                      input logic [N-1:0] y, output logic [N-1:0] r,
                                      output logic el, output logic ee, output logic eg,
                                      output int lat);
        int k;
        logic found;
        logic truth;
        logic [N-1:0] xs, ys;
        r = '0; el = 1'b0; ee = 1'b0; eg = 1'b0; lat = 1;
        if (s < 3'd2) return;
        if (s == 3'd4 || s == 3'd5) begin
            el = ($signed(x) < $signed(y));
            eg = ($signed(x) > $signed(y));
        end else begin
            el = (x < y);
            eg = (x > y);
        end
        ee = (x == y);
        k = NCHUNK;
        found = 1'b0;
        for (int c = NCHUNK - 1; c >= 0; c--) begin
            xs = x >> (c * CHUNK);
            ys = y >> (c * CHUNK);
            if (!found && (xs[CHUNK-1:0] != ys[CHUNK-1:0])) begin
                k = NCHUNK - c;
                found = 1'b1;
            end
        end
        case (s)
            3'd2:       truth = ee;
            3'd3:       truth = !ee;
            3'd4, 3'd6: truth = el;
            default:    truth = !el;
        endcase
        r[0] = truth;
        lat = k + 1;
    endfunction

    // Issue one op, scramble inputs after accept, and record what the DUT showed.
    task automatic run_op(input logic [2:0] s, input logic [N-1:0] x, input logic [N-1:0] y,
                          output int o_lat, output int o_busy, output logic [N-1:0] o_res,
                          output logic o_lt, output logic o_eq, output logic o_gt,
                          output logic o_done_after);
        @(negedge clk);
        start = 1'b1; sel = s; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        sel = 3'($urandom);
        a = N'($urandom);
        b = N'($urandom);
        o_lat = 0;
        o_busy = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                o_lat = c;
                break;
            end
            if (busy) o_busy++;
        end
        o_res = result; o_lt = lt; o_eq = eq; o_gt = gt;
        @(negedge clk);
        o_done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sel = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, lt, eq, gt} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy/done/lt/eq/gt=%b, want 00000",
                     {busy, done, lt, eq, gt});
        end
        vectors++;
        if (result !== '0) begin
            miscompares++;
            $display("FAIL reset_result: got %h, want 00", result);
        end
    endtask

    task automatic test_directed();
        logic [2:0]   ts[6] = '{3'd2, 3'd4, 3'd6, 3'd7, 3'd3, 3'd1};
        logic [N-1:0] ta[6] = '{8'h5A, 8'h80, 8'h80, 8'h12, 8'h12, 8'h33};
        logic [N-1:0] tb[6] = '{8'h5A, 8'h01, 8'h01, 8'h1F, 8'h1F, 8'hC4};
        int o_lat, o_busy, e_lat;
        logic [N-1:0] o_res, e_res;
        logic o_lt, o_eq, o_gt, o_da, e_lt, e_eq, e_gt;
        for (int i = 0; i < 6; i++) begin
            ref_model(ts[i], ta[i], tb[i], e_res, e_lt, e_eq, e_gt, e_lat);
            run_op(ts[i], ta[i], tb[i], o_lat, o_busy, o_res, o_lt, o_eq, o_gt, o_da);
            vectors++;
            if (o_lat !== e_lat) begin
                miscompares++;
                $display("FAIL dir%0d_latency: got %0d, want %0d", i, o_lat, e_lat);
            end
            vectors++;
            if (o_busy !== e_lat - 1) begin
                miscompares++;
                $display("FAIL dir%0d_busy_cycles: got %0d, want %0d", i, o_busy, e_lat - 1);
            end
            vectors++;
            if ({o_res, o_lt, o_eq, o_gt} !== {e_res, e_lt, e_eq, e_gt}) begin
                miscompares++;
                $display("FAIL dir%0d_result: got res=%h lt/eq/gt=%b%b%b, want res=%h %b%b%b",
                         i, o_res, o_lt, o_eq, o_gt, e_res, e_lt, e_eq, e_gt);
            end
            vectors++;
            if (o_da !== 1'b0) begin
                miscompares++;
                $display("FAIL dir%0d_done_pulse: done still %b one cycle later, want 0",
                         i, o_da);
            end
        end
    endtask

    task automatic test_random();
        int o_lat, o_busy, e_lat;
        logic [N-1:0] x, y, o_res, e_res;
        logic [2:0] s;
        logic o_lt, o_eq, o_gt, o_da, e_lt, e_eq, e_gt;
        for (int i = 0; i < 150; i++) begin
            s = 3'($urandom_range(0, 7));
            x = N'($urandom);
            y = N'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = {x[N-1:CHUNK], y[CHUNK-1:0]};
                default: ;
            endcase
            ref_model(s, x, y, e_res, e_lt, e_eq, e_gt, e_lat);
            run_op(s, x, y, o_lat, o_busy, o_res, o_lt, o_eq, o_gt, o_da);
            vectors++;
            if (o_lat !== e_lat || o_busy !== e_lat - 1) begin
                miscompares++;
                $display("FAIL rnd%0d_timing sel=%0d a=%h b=%h: got lat=%0d busy=%0d, want %0d/%0d",
                         i, s, x, y, o_lat, o_busy, e_lat, e_lat - 1);
            end
            vectors++;
            if ({o_res, o_lt, o_eq, o_gt} !== {e_res, e_lt, e_eq, e_gt} || o_da !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd%0d_result sel=%0d a=%h b=%h: got res=%h %b%b%b done+1=%b, want res=%h %b%b%b done+1=0",
                         i, s, x, y, o_res, o_lt, o_eq, o_gt, o_da, e_res, e_lt, e_eq, e_gt);
            end
        end
    endtask

    task automatic test_abort();
        int dones;
        @(negedge clk);
        start = 1'b1; sel = 3'd2; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, lt, eq, gt} !== 5'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL abort_state: got busy/done/lt/eq/gt=%b res=%h, want 00000 res=00",
                     {busy, done, lt, eq, gt}, result);
        end
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int dones, first_cyc, second_cyc, e_lat1, e_lat2;
        logic [N-1:0] e_res1, e_res2;
        logic e_lt1, e_eq1, e_gt1, e_lt2, e_eq2, e_gt2;
        ref_model(3'd2, 8'h5A, 8'h5A, e_res1, e_lt1, e_eq1, e_gt1, e_lat1);
        ref_model(3'd5, 8'h7F, 8'h80, e_res2, e_lt2, e_eq2, e_gt2, e_lat2);
        @(negedge clk);
        start = 1'b1; sel = 3'd2; a = 8'h5A; b = 8'h5A;
        @(posedge clk);
        #1;
        // Start stays high through SCAN (ignored) and into DONE (accepted).
        sel = 3'd5; a = 8'h7F; b = 8'h80;
        dones = 0; first_cyc = 0; second_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first_cyc == 0) begin
                    first_cyc = c;
                    vectors++;
                    if ({result, lt, eq, gt} !== {e_res1, e_lt1, e_eq1, e_gt1}) begin
                        miscompares++;
                        $display("FAIL b2b_first_result: got res=%h %b%b%b, want res=%h %b%b%b",
                                 result, lt, eq, gt, e_res1, e_lt1, e_eq1, e_gt1);
                    end
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end else if (second_cyc == 0) begin
                    second_cyc = c;
                    vectors++;
                    if ({result, lt, eq, gt} !== {e_res2, e_lt2, e_eq2, e_gt2}) begin
                        miscompares++;
                        $display("FAIL b2b_second_result: got res=%h %b%b%b, want res=%h %b%b%b",
                                 result, lt, eq, gt, e_res2, e_lt2, e_eq2, e_gt2);
                    end
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (dones !== 2 || first_cyc !== e_lat1 || second_cyc !== e_lat1 + e_lat2) begin
            miscompares++;
            $display("FAIL b2b_timing: got dones=%0d at %0d,%0d, want 2 at %0d,%0d",
                     dones, first_cyc, second_cyc, e_lat1, e_lat1 + e_lat2);
        end
    endtask

    task automatic test_ignore_busy_start();
        int dones, done_cyc, e_lat;
        logic [N-1:0] e_res;
        logic e_lt, e_eq, e_gt;
        ref_model(3'd7, 8'h12, 8'h1F, e_res, e_lt, e_eq, e_gt, e_lat);
        @(negedge clk);
        start = 1'b1; sel = 3'd7; a = 8'h12; b = 8'h1F;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0; done_cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (done_cyc == 0) done_cyc = c;
                vectors++;
                if ({result, lt, eq, gt} !== {e_res, e_lt, e_eq, e_gt}) begin
                    miscompares++;
                    $display("FAIL ignore_result: got res=%h %b%b%b, want res=%h %b%b%b",
                             result, lt, eq, gt, e_res, e_lt, e_eq, e_gt);
                end
            end
            // Stray request in the first SCAN cycle must be dropped.
            if (c == 1) begin
                start = 1'b1; sel = 3'd2; a = 8'h00; b = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (dones !== 1 || done_cyc !== e_lat) begin
            miscompares++;
            $display("FAIL ignore_count: got %0d dones first at %0d, want 1 at %0d",
                     dones, done_cyc, e_lat);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        test_ignore_busy_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmp_seq_unit.md
Name: cmp_seq_unit

Overview:
Parametrised, multi-cycle comparison unit for the ALU compare path. It replaces the fixed 8-bit, 6-way result select with a chunk-serial magnitude comparator of generic width. The comparator scans operands MSB-chunk first and terminates early on the first differing chunk. It supports signed and unsigned ordering, presents the selected predicate as an N-bit zero-extended result plus lt/eq/gt flags, and uses a start/done handshake toward the core sequencer.

Parameters:
N, 8, operand and result width in bits
CHUNK, 4, bits compared per cycle; N must be a multiple of CHUNK (elaboration-time assertion)
NCHUNK, N/CHUNK, derived, number of chunks; not overridable

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; accepted only when busy==0
sel  input  3  predicate: 2=EQ, 3=NE, 4=LT (signed), 5=GE (signed), 6=LTU, 7=GEU; 0/1 invalid
a  input  N  left operand, sampled on accepted start
b  input  N  right operand, sampled on accepted start
busy  output  1  high while in SCAN
done  output  1  one-cycle pulse: result/flags updated this cycle
result  output  N  predicate outcome, zero-extended (bit0 = truth), held until next done
lt  output  1  a<b under the op's signedness, held with result
eq  output  1  a==b, held with result
gt  output  1  a>b under the op's signedness, held with result

Behaviour:
- Reset: the state machine goes to IDLE. busy, done, lt, eq and gt are set to 0, and result is set to 0. rst has priority over everything, including an in-flight SCAN. An aborted operation produces no done.
- States:
  - IDLE: waiting for start.
  - SCAN: comparing one chunk per cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state==SCAN).
- Accept: start with state IDLE or DONE. A start that arrives during the DONE cycle is accepted, so back-to-back operations need no idle gap. A start while busy is ignored and has no side effects.
- On accept with a valid sel:
  - Latch sel.
  - Latch a and b. For sel 4/5, invert bit N-1 of both latched operands, which maps signed order onto unsigned order.
  - Set chunk index idx = NCHUNK-1 and go to SCAN.
- On accept with an invalid sel (0/1): go directly to DONE. result=0, lt=eq=gt=0, latency 1.
- SCAN, each cycle, compare the latched chunk [idx*CHUNK +: CHUNK] unsigned:
  - Chunks differ: capture lt or gt and go to DONE.
  - Chunks equal and idx==0: capture eq and go to DONE.
  - Otherwise: decrement idx and stay in SCAN.
- Result mapping, computed and registered on the SCAN→DONE transition so that it is visible in the DONE cycle:
  - EQ=eq, NE=!eq, LT/LTU=lt, GE/GEU=!lt.
  - result = {(N-1)'b0, bit}.
  - Flags reflect the comparison actually performed.
- Latency: with k = number of chunks examined (1..NCHUNK), done asserts k+1 cycles after the accepting edge. Worst case is NCHUNK+1 cycles, which occurs for equal operands or a difference only in chunk 0.
- Operand changes on a/b/sel after accept have no effect on the in-flight operation.
- N==CHUNK is legal: a single SCAN cycle.

Decomposition:
- Shared package cmp_pkg:
  - cmp_op_e enum for sel codes 0–7, including OP_INVALID0/1.
  - cmp_state_e {IDLE, SCAN, DONE}.
  - Helper function is_signed_op(op).
- Sub-module cmp_chunk #(W): purely combinational W-bit unsigned compare with outputs lt/eq/gt. It is instantiated once on the idx-selected slice.

Test Plan:
- N=8, CHUNK=4, sel=2, a=0x5A, b=0x5A: busy high 2 cycles, done 3 cycles after accept, result=0x01, eq=1, lt=gt=0.
- sel=4, a=0x80, b=0x01 (signed): early exit on the upper chunk, done at +2, result=0x01, lt=1. Repeat with sel=6: result=0x00, gt=1, done at +2.
- sel=7, a=0x12, b=0x1F: upper chunks equal, lower 2<F, done at +3, result=0x00, lt=1. With sel=3 (NE) on the same operands: result=0x01.
- sel=1, any operands: done at +1, result=0x00, lt=eq=gt=0, busy never asserts.
- Start sel=2 a=b=0xFF; after 1 SCAN cycle, assert rst for one cycle: next cycle busy=0, done=0, result=0 and flags=0; no done pulse follows.
- Back-to-back: start held high across the DONE cycle with a new op (sel=5, a=0x7F, b=0x80). The second op is accepted in the DONE cycle, then done with result=0x01, gt=1. A start pulse during SCAN is ignored: exactly one done per accepted start.
